wbucmdexec: RTL



---
 rtl/wbu_pkg.sv | 7 +
 rtl/wbutimeout.sv | 16 +
 rtl/wbucmdexec.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wbu_pkg.sv
// wbu_pkg: shared codeword width, opcodes, response prefixes and FSM states for the debug-bus bridge
package wbu_pkg;
  localparam int CW_W = 36;
  localparam logic [1:0] OP_SETADDR = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_PING = 2'b11;
  localparam logic [3:0] RSP_READ = 4'h1, RSP_WACK = 4'h2, RSP_BUSERR = 4'h3, RSP_ADDR = 4'h4, RSP_RESET = 4'h5, RSP_PING = 4'h6;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
endpackage

// File: rtl/wbutimeout.sv
// wbutimeout: bus watchdog down-counter; clk/rst, run (cycle open), restart (bus progress) in, expired out
module wbutimeout #(
  parameter int LG = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);
  logic [LG-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || !run || restart) cnt <= '1;
    else if (cnt != '0) cnt <= cnt - LG'(1);
  assign expired = run && !restart && cnt == '0;
endmodule

// File: rtl/wbucmdexec.sv
// wbucmdexec: executes 36-bit bus codewords on a pipelined Wishbone master; i_stb/i_codword in, o_stb/o_codword out, o_wb_* master port
module wbucmdexec
  import wbu_pkg::*;
#(
  parameter int LGTIMEOUT = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stb,
  input  logic [CW_W-1:0] i_codword,
  output logic            o_busy,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [31:0]     o_wb_addr,
  output logic [31:0]     o_wb_data,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [31:0]     i_wb_data,
  output logic            o_stb,
  output logic [CW_W-1:0] o_codword
);
  state_t state;
  logic [31:0] addr;
  logic inc, pending, take, restart, expired, unused;
  logic [10:0] count, issued, acked;
  assign o_wb_addr = addr;
  assign o_busy = state != S_IDLE;
  assign take = i_stb && !o_busy && !pending;
  assign restart = (o_wb_stb && !i_wb_stall) || i_wb_ack;
  assign unused = i_codword[33];
  wbutimeout #(.LG(LGTIMEOUT)) u_timeout (
    .clk(i_clk),
    .rst(i_rst),
    .run(o_wb_cyc),
    .restart(restart),
    .expired(expired)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= S_IDLE;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_we <= 1'b0;
      o_wb_data <= 32'h0;
      addr <= 32'h0;
      inc <= 1'b1;
      count <= 11'd0;
      issued <= 11'd0;
      acked <= 11'd0;
      o_stb <= 1'b0;
      o_codword <= '0;
      pending <= 1'b1;
    end else begin
      o_stb <= 1'b0;
      if (pending) begin
        pending <= 1'b0;
        o_stb <= 1'b1;
        o_codword <= {RSP_RESET, 32'h0};
      end else if (take) begin
        case (i_codword[35:34])
          OP_SETADDR: begin
            addr <= i_codword[31:0];
            inc <= ~i_codword[32];
            o_stb <= 1'b1;
            o_codword <= {RSP_ADDR, i_codword[31:0]};
          end
          OP_WRITE: begin
            o_wb_data <= i_codword[31:0];
            {o_wb_cyc, o_wb_stb, o_wb_we} <= 3'b111;
            state <= S_WRITE;
          end
          OP_READ: begin
            count <= {i_codword[9:0] == 10'd0, i_codword[9:0]};
            issued <= 11'd0;
            acked <= 11'd0;
            {o_wb_cyc, o_wb_stb, o_wb_we} <= 3'b110;
            state <= S_READ;
          end
          default: begin
            o_stb <= 1'b1;
            o_codword <= {RSP_PING, 32'h0};
          end
        endcase
      end else if (state != S_IDLE && (i_wb_err || expired)) begin
        // err beats a simultaneous ack; any reads still outstanding are abandoned
        {o_wb_cyc, o_wb_stb, o_wb_we} <= 3'b000;
        o_stb <= 1'b1;
        o_codword <= {RSP_BUSERR, 32'h0};
        state <= S_IDLE;
      end else if (state == S_WRITE) begin
        if (o_wb_stb && !i_wb_stall) begin
          o_wb_stb <= 1'b0;
          addr <= addr + {31'h0, inc};
        end
        if (i_wb_ack) begin
          o_stb <= 1'b1;
          o_codword <= {RSP_WACK, 32'h0};
          {o_wb_cyc, o_wb_stb, o_wb_we} <= 3'b000;
          state <= S_IDLE;
        end
      end else if (state == S_READ) begin
        if (o_wb_stb && !i_wb_stall) begin
          issued <= issued + 11'd1;
          addr <= addr + {31'h0, inc};
          o_wb_stb <= (issued + 11'd1) != count;
        end
        if (i_wb_ack) begin
          o_stb <= 1'b1;
          o_codword <= {RSP_READ, i_wb_data};
          acked <= acked + 11'd1;
          if ((acked + 11'd1) == count) begin
            {o_wb_cyc, o_wb_stb} <= 2'b00;
            state <= S_IDLE;
          end
        end
      end
    end
endmodule
